// File: rtl/program_loader_pkg.sv
// Shared types and frame field widths for the serial program loader.
package program_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         COUNT_W           = 16;
  localparam int         WORD_W            = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHECK,
    S_LOADED,
    S_FAIL
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte receive strobe in, instruction-memory write port and core control out.
interface program_loader_if;
  import program_loader_pkg::*;

  // RX side: RX_VALID is a one-cycle strobe with no back-pressure; a byte is
  // taken in exactly the cycle it is strobed. Write side: PROGB low for one
  // cycle qualifies INPUT_ADDRESS/INPUT_INSTRUCTION.
  logic              RX_VALID;
  logic [7:0]        RX_DATA;
  logic              PROGB;
  logic [WORD_W-1:0] INPUT_INSTRUCTION;
  logic [31:0]       INPUT_ADDRESS;
  logic              CPU_RESET;
  logic              DONE;
  logic              ERROR;

  modport master (
    input  RX_VALID, RX_DATA,
    output PROGB, INPUT_INSTRUCTION, INPUT_ADDRESS, CPU_RESET, DONE, ERROR
  );

  modport slave (
    output RX_VALID, RX_DATA,
    input  PROGB, INPUT_INSTRUCTION, INPUT_ADDRESS, CPU_RESET, DONE, ERROR
  );

endinterface

// File: rtl/program_loader_word_asm.sv
// Little-endian byte-to-word assembler; word_ready fires on the 4th byte strobe.
module loader_word_asm
  import program_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              word_ready,
  output logic [WORD_W-1:0] word_out
);

  logic [1:0]        byte_cnt_q;
  logic [WORD_W-1:0] asm_q;

  // word_out already contains the incoming byte, so on the 4th strobe it is
  // the complete word and can be registered by the caller on the same edge.
  always_comb begin
    word_out                   = asm_q;
    word_out[8*byte_cnt_q +: 8] = byte_in;
    word_ready                 = byte_valid && (byte_cnt_q == 2'd3);
  end

  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      byte_cnt_q <= 2'd0;
      asm_q      <= '0;
    end else if (byte_valid) begin
      asm_q      <= word_out;
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Serial frame loader writing words into instruction memory while holding the core in reset.
// Optional trailing XOR checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         MAX_WORDS = 1024,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  program_loader_if.master  bus,
  output state_t            state_dbg
);

  state_t             state_q, state_d;
  logic [7:0]         len_lo_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] index_q;
  logic               progb_q;
  logic [WORD_W-1:0]  instr_q;
  logic [31:0]        addr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]         chk_q;
`endif

  logic               is_sync, start, len_bad, last_word;
  logic               asm_valid, word_ready;
  logic [WORD_W-1:0]  word;
  logic [COUNT_W-1:0] len_n;

  assign is_sync   = bus.RX_VALID && (bus.RX_DATA == SYNC_BYTE);
  assign start     = is_sync && (state_q == S_IDLE || state_q == S_LOADED || state_q == S_FAIL);
  assign len_n     = {bus.RX_DATA, len_lo_q};
  assign len_bad   = (len_n == '0) || (32'(len_n) > 32'(MAX_WORDS));
  assign asm_valid = bus.RX_VALID && (state_q == S_DATA);
  assign last_word = word_ready && (index_q == count_q - 16'd1);

  loader_word_asm u_word_asm (
    .CLK        (CLK),
    .RESET      (RESET),
    .clr        (state_q != S_DATA),
    .byte_valid (asm_valid),
    .byte_in    (bus.RX_DATA),
    .word_ready (word_ready),
    .word_out   (word)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (is_sync) state_d = S_LEN0;
      S_LEN0:   if (bus.RX_VALID) state_d = S_LEN1;
      S_LEN1:   if (bus.RX_VALID) state_d = len_bad ? S_FAIL : S_DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_DATA:   if (last_word) state_d = S_CHECK;
      S_CHECK:  if (bus.RX_VALID) state_d = (bus.RX_DATA == chk_q) ? S_LOADED : S_FAIL;
`else
      S_DATA:   if (last_word) state_d = S_LOADED;
      S_CHECK:  state_d = S_FAIL;
`endif
      S_LOADED: if (is_sync) state_d = S_LEN0;
      S_FAIL:   if (is_sync) state_d = S_LEN0;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.PROGB             = progb_q;
    bus.INPUT_INSTRUCTION = instr_q;
    bus.INPUT_ADDRESS     = addr_q;
    bus.CPU_RESET         = (state_q != S_LOADED);
    bus.DONE              = (state_q == S_LOADED);
    bus.ERROR             = (state_q == S_FAIL);
    state_dbg             = state_q;
  end

  // Write port is registered: the edge that takes the 4th byte launches the
  // one-cycle PROGB=0 write, and the next byte can arrive in that same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      progb_q  <= 1'b1;
      instr_q  <= '0;
      addr_q   <= BASE_ADDR;
      index_q  <= '0;
      count_q  <= '0;
      len_lo_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_q    <= '0;
`endif
    end else begin
      progb_q <= 1'b1;
      if (start) begin
        index_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk_q   <= '0;
`endif
      end
      if (state_q == S_LEN0 && bus.RX_VALID) len_lo_q <= bus.RX_DATA;
      if (state_q == S_LEN1 && bus.RX_VALID) count_q  <= len_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (asm_valid) chk_q <= chk_q ^ bus.RX_DATA;
`endif
      if (word_ready) begin
        progb_q <= 1'b0;
        instr_q <= word;
        addr_q  <= BASE_ADDR + 32'({index_q, 2'b00});
        index_q <= index_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard on the PROGB port.
// Checksum frames are exercised when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
  import program_loader_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_dbg;

  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader dut (
    .CLK       (clk),
    .RESET     (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  logic [63:0] exp_q[$];
  logic [63:0] exp_w;
  int          checks    = 0;
  int          failures  = 0;
  int          pulse_cnt = 0;
  logic        prev_progb = 1'b1;
  logic [7:0]  tb_chk;

  // Scoreboard: every PROGB=0 cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.PROGB === 1'b0) begin
      pulse_cnt++;
      checks++;
      assert (prev_progb === 1'b1) else begin
        failures++;
        $error("FAIL progb_width observed=0 expected=1 on previous cycle");
      end
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=%h data=%h expected=none",
               bus.INPUT_ADDRESS, bus.INPUT_INSTRUCTION);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        checks++;
        assert ({bus.INPUT_ADDRESS, bus.INPUT_INSTRUCTION} === exp_w) else begin
          failures++;
          $error("FAIL write observed addr=%h data=%h expected addr=%h data=%h",
                 bus.INPUT_ADDRESS, bus.INPUT_INSTRUCTION, exp_w[63:32], exp_w[31:0]);
        end
      end
    end
    prev_progb = bus.PROGB;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.RX_VALID = 1'b1;
    bus.RX_DATA  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.RX_VALID = 1'b0;
      bus.RX_DATA  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.RX_VALID = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    tb_chk = 8'h00;
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] w);
    exp_q.push_back({a, w});
    for (int k = 0; k < 4; k++) begin
      tb_chk = tb_chk ^ w[8*k +: 8];
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic send_check(input logic [7:0] flip);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(tb_chk ^ flip);
`else
    if (flip != 8'h00) tb_chk = tb_chk ^ flip;
`endif
  endtask

  initial begin
    logic [31:0] w;
    rst          = 1'b1;
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_progb", 32'(bus.PROGB), 32'd1);
    check("rst_instr", bus.INPUT_INSTRUCTION, 32'h0);
    check("rst_addr", bus.INPUT_ADDRESS, 32'h0);
    check("rst_cpu_reset", 32'(bus.CPU_RESET), 32'd1);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_error", 32'(bus.ERROR), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b0;

    // Two-word frame, good checksum when enabled.
    pulse_cnt = 0;
    send_hdr(16'd2);
    send_word(32'h0, 32'h0000_0013);
    send_word(32'h4, 32'h0010_0093);
    check("chk_byte_value", 32'(tb_chk), 32'h90);
    send_check(8'h00);
    idle(3);
    check("ok_pulses", 32'(pulse_cnt), 32'd2);
    check("ok_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ok_done", 32'(bus.DONE), 32'd1);
    check("ok_cpu_reset", 32'(bus.CPU_RESET), 32'd0);
    check("ok_error", 32'(bus.ERROR), 32'd0);
    check("ok_hold_instr", bus.INPUT_INSTRUCTION, 32'h0010_0093);
    check("ok_hold_addr", bus.INPUT_ADDRESS, 32'h4);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Same frame, bad checksum: writes still happen, then FAIL.
    pulse_cnt = 0;
    send_hdr(16'd2);
    send_word(32'h0, 32'h0000_0013);
    send_word(32'h4, 32'h0010_0093);
    send_check(8'h01);
    idle(3);
    check("bad_pulses", 32'(pulse_cnt), 32'd2);
    check("bad_error", 32'(bus.ERROR), 32'd1);
    check("bad_done", 32'(bus.DONE), 32'd0);
    check("bad_cpu_reset", 32'(bus.CPU_RESET), 32'd1);
`endif

    // Restart from a finished state, then zero length.
    pulse_cnt = 0;
    send_byte(8'hA5);
    idle(1);
    check("restart_state", 32'(state_dbg), 32'(S_LEN0));
    check("restart_done", 32'(bus.DONE), 32'd0);
    check("restart_error", 32'(bus.ERROR), 32'd0);
    check("restart_cpu_reset", 32'(bus.CPU_RESET), 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(2);
    check("len0_state", 32'(state_dbg), 32'(S_FAIL));
    check("len0_error", 32'(bus.ERROR), 32'd1);

    // Length 1025 exceeds the memory depth.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    idle(2);
    check("len_big_state", 32'(state_dbg), 32'(S_FAIL));
    check("len_big_error", 32'(bus.ERROR), 32'd1);
    check("len_fail_pulses", 32'(pulse_cnt), 32'd0);

    // Non-sync bytes ignored in IDLE, back-to-back strobes.
    do_reset();
    send_byte(8'h11);
    send_byte(8'h22);
    check("ignore_11_state", 32'(state_dbg), 32'(S_IDLE));
    send_byte(8'hA5);
    check("ignore_22_state", 32'(state_dbg), 32'(S_IDLE));
    idle(1);
    check("sync_state", 32'(state_dbg), 32'(S_LEN0));

    // Reset mid-word, then reset on the edge of a 4th byte.
    do_reset();
    pulse_cnt = 0;
    send_hdr(16'd1);
    send_byte(8'h13);
    send_byte(8'h00);
    do_reset();
    check("midword_state", 32'(state_dbg), 32'(S_IDLE));
    send_hdr(16'd1);
    send_byte(8'h44);
    send_byte(8'h33);
    send_byte(8'h22);
    @(negedge clk);
    bus.RX_DATA = 8'h11;
    rst         = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.RX_VALID = 1'b0;
    check("rst_pending_progb", 32'(bus.PROGB), 32'd1);
    check("rst_pending_state", 32'(state_dbg), 32'(S_IDLE));
    send_hdr(16'd1);
    send_word(32'h0, 32'hDEAD_BEEF);
    send_check(8'h00);
    idle(3);
    check("after_rst_pulses", 32'(pulse_cnt), 32'd1);
    check("after_rst_queue", 32'(exp_q.size()), 32'd0);
    check("after_rst_done", 32'(bus.DONE), 32'd1);
    check("after_rst_addr", bus.INPUT_ADDRESS, 32'h0);

    // Full-depth frame, RX_VALID every cycle.
    do_reset();
    pulse_cnt = 0;
    send_hdr(16'd1024);
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      send_word(32'(i) * 32'd4, w);
    end
    send_check(8'h00);
    idle(3);
    check("full_pulses", 32'(pulse_cnt), 32'd1024);
    check("full_queue", 32'(exp_q.size()), 32'd0);
    check("full_last_addr", bus.INPUT_ADDRESS, 32'hFFC);
    check("full_done", 32'(bus.DONE), 32'd1);
    check("full_cpu_reset", 32'(bus.CPU_RESET), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024, is the largest accepted word count and matches instruction memory depth.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, is the frame start marker.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of the first written word.
REQ-004 The block SHALL have port CLK, input, 1, the single clock.
REQ-005 The block SHALL have port RESET, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port RX_VALID, input, 1, a one-cycle strobe meaning RX_DATA holds a received byte.
REQ-007 The block SHALL have port RX_DATA, input, 8, the received byte.
REQ-008 The block SHALL have port PROGB, output, 1, driven low for exactly one cycle per word write to instruction memory.
REQ-009 The block SHALL have port INPUT_INSTRUCTION, output, 32, the word to write.
REQ-010 The block SHALL have port INPUT_ADDRESS, output, 32, the byte address of the word to write.
REQ-011 The block SHALL have port CPU_RESET, output, 1, which holds the core in reset while high.
REQ-012 The block SHALL have port DONE, output, 1, high after a load completes successfully.
REQ-013 The block SHALL have port ERROR, output, 1, high after a load fails.

Function
REQ-014 The frame SHALL be: SYNC_BYTE, word count N (2 bytes, little-endian), N words (4 bytes each, little-endian), then a checksum byte when the checksum feature is enabled (see REQ-031/032).
REQ-015 The FSM SHALL have states IDLE, LEN0, LEN1, DATA, CHECK, LOADED and FAIL.
REQ-016 The FSM SHALL advance only on cycles where RX_VALID=1; a byte SHALL be consumed in the cycle it is strobed.
REQ-017 In IDLE, the FSM SHALL ignore every byte except SYNC_BYTE, which moves it to LEN0.
REQ-018 From LEN0 the FSM SHALL go to LEN1, and from LEN1 it SHALL go to DATA; if N==0 or N>MAX_WORDS, it SHALL go to FAIL instead of DATA.
REQ-019 In DATA, bytes SHALL be shifted into a 32-bit assembler with byte k landing in bits [8k+7:8k].
REQ-020 On the 4th byte of a word, the next cycle SHALL present PROGB=0, INPUT_INSTRUCTION=the assembled word and INPUT_ADDRESS=BASE_ADDR+4*index.
REQ-021 PROGB SHALL be 1 in every other cycle.
REQ-022 A byte strobed during a PROGB=0 cycle SHALL be accepted into the assembler without loss, so back-to-back RX_VALID is supported.
REQ-023 INPUT_ADDRESS and INPUT_INSTRUCTION SHALL hold their values between writes.
REQ-024 After word N is written, the FSM SHALL go to CHECK when the checksum is enabled, else to LOADED.
REQ-025 The checksum SHALL be the XOR of all N*4 payload bytes; a matching byte in CHECK SHALL go to LOADED, and a mismatch SHALL go to FAIL.
REQ-026 CPU_RESET SHALL be high in every state except LOADED.
REQ-027 DONE SHALL be high only in LOADED, and ERROR SHALL be high only in FAIL.
REQ-028 In LOADED or FAIL, a SYNC_BYTE SHALL restart the load: go to LEN0, reassert CPU_RESET, clear DONE and ERROR, and reset the word index and the checksum.

Reset
REQ-029 RESET sampled high SHALL force IDLE, PROGB=1, INPUT_INSTRUCTION=0, INPUT_ADDRESS=BASE_ADDR, CPU_RESET=1, DONE=0, ERROR=0, and clear the index, byte count, assembler and checksum.
REQ-030 RESET during a pending write cycle SHALL take priority, so PROGB is 1 in the cycle after RESET is sampled; words already written are not rolled back.

Configuration
REQ-031 With macro PROGRAM_LOADER_CHECKSUM_EN defined, the CHECK state and the checksum byte SHALL exist as in REQ-025.
REQ-032 Without PROGRAM_LOADER_CHECKSUM_EN, the frame SHALL have no checksum byte, CHECK SHALL be unreachable, and the last word SHALL go directly to LOADED.

Structure
REQ-033 Package program_loader_pkg SHALL hold the state enumeration, the default SYNC_BYTE and the frame field widths (count 16 bits, word 32 bits).
REQ-034 Sub-module loader_word_asm SHALL contain the byte-to-word assembler (byte counter 0..3, word-ready pulse) and the FSM remains in program_loader.

Verification
REQ-035 Send A5 02 00 13 00 00 00 93 00 10 00 plus checksum 0x90 -> PROGB low twice: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; then DONE=1, CPU_RESET=0.
REQ-036 Send the same frame with checksum 0x91 -> both writes occur, then ERROR=1, DONE=0, CPU_RESET=1.
REQ-037 Send A5 00 00, and separately A5 01 04 -> FAIL with no PROGB pulse.
REQ-038 Send bytes 11 22 A5 with RX_VALID every cycle -> 11 and 22 ignored, and LEN0 entered after A5.
REQ-039 Assert RESET mid-word after 2 data bytes, then send a full valid 1-word frame -> the single write lands at addr 0x0.
REQ-040 Send a 1024-word frame with RX_VALID high every cycle -> 1024 one-cycle PROGB pulses, last addr 0xFFC, with no dropped bytes.
